// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes from state only, and a bubble presents NOP_VALUE on out_data.
module pipe_stage_buf #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_p0, main_d;
    logic [DATA_W-1:0] skid_p1, skid_d;
    logic              push, pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = main_p0;

    always_comb begin
        state_d = state_q;
        main_d  = main_p0;
        skid_d  = skid_p1;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        // Leave a NOP behind so a bubble decodes harmlessly downstream.
                        main_d  = NOP_VALUE;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_p1;
                        skid_d  = NOP_VALUE;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // Registered state, data and handshake outputs; state encoding equals occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            main_p0   <= NOP_VALUE;
            skid_p1   <= NOP_VALUE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
            stall_cnt <= '0;
        end else begin
            state_q   <= state_d;
            main_p0   <= main_d;
            skid_p1   <= skid_d;
            out_valid <= (state_d != EMPTY);
            in_ready  <= (state_d != FULL);
            occupancy <= state_d;
            if (out_valid && !out_ready)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed stimulus with a scoreboard queue and a
// monitor that checks every popped entry against the order of accepted pushes.
module tb_pipe_stage_buf;

    localparam int                DATA_W = 32;
    localparam int                CNT_W  = 4;
    localparam logic [DATA_W-1:0] NOP    = '0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    pipe_stage_buf #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, record accepted pushes mid-cycle, return 1ns after the edge.
    task automatic cyc(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                       input logic fl, input logic rn);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        @(negedge clk);
        if (!rn || fl)
            exp_q.delete();
        else if (iv && in_ready)
            exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every real pop must match the oldest accepted push; bubbles must show NOP.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !flush && out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
                end else begin
                    chk("out_data_order", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end else if (rst_n && out_valid === 1'b0) begin
                chk("bubble_nop", 64'(out_data), 64'(NOP));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then idle
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'(NOP));
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Streaming at full rate: one cycle latency, occupancy stays 1
        for (int i = 1; i <= 8; i++) begin
            cyc(1, DATA_W'(i), 1, 0, 1);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data",  64'(out_data),  64'(i));
            chk("stream_occ",   64'(occupancy), 64'd1);
        end
        cyc(0, 0, 1, 0, 1);
        chk("drain_occ", 64'(occupancy), 64'd0);
        chk("stream_no_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure fills the skid register
        cyc(1, 32'hA, 0, 0, 1);
        chk("bp_occ1", 64'(occupancy), 64'd1);
        cyc(1, 32'hB, 0, 0, 1);
        chk("bp_occ2",     64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready),  64'd0);
        chk("bp_stall1",   64'(stall_cnt), 64'd1);
        cyc(1, 32'hEE, 0, 0, 1);
        chk("bp_stall2",   64'(stall_cnt), 64'd2);
        chk("bp_hold_occ", 64'(occupancy), 64'd2);
        chk("bp_head",     64'(out_data),  64'hA);
        cyc(0, 0, 1, 0, 1);
        chk("bp_ready_back", 64'(in_ready),  64'd1);
        chk("bp_occ_after1", 64'(occupancy), 64'd1);
        chk("bp_head2",      64'(out_data),  64'hB);
        cyc(0, 0, 1, 0, 1);
        chk("bp_empty", 64'(occupancy), 64'd0);

        // Flush in FULL with a same-cycle push of 0xC
        cyc(1, 32'hA, 0, 0, 1);
        cyc(1, 32'hB, 0, 0, 1);
        chk("fl_full", 64'(occupancy), 64'd2);
        cyc(1, 32'hC, 0, 1, 1);
        chk("fl_occ",       64'(occupancy), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_data",  64'(out_data),  64'(NOP));
        chk("fl_in_ready",  64'(in_ready),  64'd1);
        chk("fl_stall_kept", 64'(stall_cnt), 64'd4);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        chk("fl_no_c", 64'(out_valid), 64'd0);

        // Stall counter saturation at 2^CNT_W-1
        cyc(1, 32'h11, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 0, 0, 1);
        chk("sat_15", 64'(stall_cnt), 64'd15);
        cyc(0, 0, 0, 1, 1);
        chk("sat_after_flush", 64'(stall_cnt), 64'd15);
        chk("sat_flush_occ",   64'(occupancy), 64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("sat_reset", 64'(stall_cnt), 64'd0);

        // Reset together with flush and push 0xD while in ONE
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h21, 0, 0, 1);
        chk("rf_one", 64'(occupancy), 64'd1);
        cyc(1, 32'hD, 0, 1, 0);
        chk("rf_out_valid", 64'(out_valid), 64'd0);
        chk("rf_out_data",  64'(out_data),  64'(NOP));
        chk("rf_in_ready",  64'(in_ready),  64'd1);
        chk("rf_occ",       64'(occupancy), 64'd0);
        chk("rf_stall",     64'(stall_cnt), 64'd0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        chk("rf_no_d", 64'(out_valid), 64'd0);
        chk("leftover_entries", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register, the next generation of the fixed 32-bit PC+4/instruction stage register. It replaces the write-enable/flush pair with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never drops an instruction and never forms a combinational ready path. It sits between any two processor stages (IF->ID, ID->EX, ...); flush turns the stage into a bubble that carries a configurable NOP pattern.

Parameters:
DATA_W, 64, payload width (e.g. PC+4 concatenated with the instruction word)
NOP_VALUE, 0, payload presented while the stage holds a bubble
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  discard all held entries this cycle
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept (registered, no combinational path from out_ready)
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a real entry
out_ready  input  1  downstream accepts out_data
out_data  output  DATA_W  head entry; NOP_VALUE when out_valid=0
occupancy  output  2  number of held entries (0..2)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (head, drives out_data) and skid register; each has a valid bit.
- States: EMPTY (occ 0), ONE (main valid), FULL (main and skid valid). occupancy encodes the state.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is driven from state only.
- EMPTY: push -> main<=in_data, ONE. No push -> stay.
- ONE: push & pop -> main<=in_data, stay ONE. Push & !pop -> skid<=in_data, FULL. Pop & !push -> EMPTY. Neither -> hold.
- FULL: pop -> main<=skid, ONE. No push is possible. No pop -> hold.
- Latency: in_data accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when empty.
- Throughput: 1 entry/cycle when out_ready=1 continuously.
- Order is strictly FIFO. An entry is never duplicated or lost except by flush/reset.
- While out_valid=0, out_data=NOP_VALUE. Main data is written to NOP_VALUE on pop-to-empty and on flush, so downstream decoding of a bubble sees a NOP.
- flush=1: next state EMPTY and both data registers <= NOP_VALUE. A same-cycle push is dropped and a same-cycle pop is ignored. Flush outranks every handshake event.
- Reset (rst_n=0 at posedge): EMPTY, both data registers NOP_VALUE, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0. Reset outranks flush. Reset mid-transfer discards held entries.
- stall_cnt: +1 on every cycle with out_valid & !out_ready. It holds at 2^CNT_W-1 and is cleared only by reset; flush does not clear it.
- Upstream may change in_data while in_ready=0. Only pushed values are ever stored.

Test Plan:
- Reset, then rst_n=1, idle -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- Stream 0x1..0x8 with in_valid=1 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, one cycle after each push, occupancy stays 1.
- Push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments per cycle. Raise out_ready -> 0xA then 0xB, nothing lost; in_ready returns 1 the cycle after the first pop.
- In FULL (0xA,0xB), assert flush with in_valid=1, in_data=0xC -> next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE, and 0xC is never output.
- With CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Flush leaves 15; reset gives 0.
- rst_n=0 in the same cycle as flush and push 0xD in state ONE -> all outputs at reset values, 0xD is not stored.
